// File: rtl/control_pkg.sv
// control_pkg: states, opcodes, mux selects and output bundle for the multicycle control unit (OVERFLOW_TRAP_EN adds TRAP)
package control_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, WB, MEMRD, STORE, BRANCH, CALL, RET, HALT
`ifdef OVERFLOW_TRAP_EN
    , TRAP
`endif
  } state_t;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_AADD = 4'h1;
  localparam logic [3:0] OP_ASUB = 4'h2;
  localparam logic [3:0] OP_LDM  = 4'h3;
  localparam logic [3:0] OP_LDS  = 4'h4;
  localparam logic [3:0] OP_STM  = 4'h5;
  localparam logic [3:0] OP_CMP  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_CALL = 4'h9;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [2:0] TRAP_PC_SEL = 3'd4;
  localparam logic [2:0] MEMDST_SHELLEY = 3'd3;
  localparam logic [2:0] PCSRC_IMM = 3'd1;
  localparam logic [2:0] PCSRC_RA = 3'd2;
  localparam logic [2:0] SPSRC_DEC = 3'd1;
  localparam logic [2:0] SPSRC_INC = 3'd2;
  localparam logic [1:0] REGSRC_ALU = 2'd1;
  localparam logic RASRC_FAULT = 1'b1;
  typedef struct packed {
    logic       mem_write;
    logic [1:0] mem_src;
    logic [2:0] mem_dst;
    logic       pc_write;
    logic [2:0] pc_src;
    logic       sp_write;
    logic [2:0] sp_src;
    logic       inst_write;
    logic       mary_write;
    logic [1:0] mary_src;
    logic       shelley_write;
    logic [1:0] shelley_src;
    logic       comp_write;
    logic       ra_write;
    logic       ra_src;
    logic       src_a;
    logic [1:0] src_b;
    logic [3:0] alu_op;
    logic       halted;
    logic       trap;
  } ctrl_t;
endpackage

// File: rtl/control_output_decode.sv
// control_output_decode: Moore decode of state + opcode into the datapath control bundle
module control_output_decode
  import control_pkg::*;
(
  input  state_t     state_i,
  input  logic [3:0] opcode_i,
  input  logic       comp_i,
  output ctrl_t      ctrl_o
);
  // every field defaults to 0 so each state only names the enables it raises
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.inst_write = 1'b1;
        ctrl_o.pc_write = 1'b1;
      end
      EXEC: begin
        ctrl_o.alu_op = (opcode_i == OP_AADD) ? ALU_ADD : ALU_SUB;
        ctrl_o.comp_write = (opcode_i == OP_CMP);
      end
      WB: begin
        ctrl_o.mary_write = 1'b1;
        ctrl_o.mary_src = REGSRC_ALU;
      end
      MEMRD: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.mary_write = (opcode_i == OP_LDM);
        ctrl_o.shelley_write = (opcode_i == OP_LDS);
      end
      STORE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.mem_dst = MEMDST_SHELLEY;
      end
      BRANCH: begin
        ctrl_o.pc_write = (opcode_i == OP_JMP) | comp_i;
        ctrl_o.pc_src = PCSRC_IMM;
      end
      CALL: begin
        ctrl_o.ra_write = 1'b1;
        ctrl_o.sp_write = 1'b1;
        ctrl_o.sp_src = SPSRC_DEC;
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src = PCSRC_IMM;
      end
      RET: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src = PCSRC_RA;
        ctrl_o.sp_write = 1'b1;
        ctrl_o.sp_src = SPSRC_INC;
      end
      HALT: ctrl_o.halted = 1'b1;
`ifdef OVERFLOW_TRAP_EN
      TRAP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src = TRAP_PC_SEL;
        ctrl_o.ra_write = 1'b1;
        ctrl_o.ra_src = RASRC_FAULT;
        ctrl_o.trap = 1'b1;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle FSM for the mary/shelley datapath; OVERFLOW_TRAP_EN enables the overflow trap
module multicycle_control_unit
  import control_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        comp,
  input  logic        overflow,
  output logic        MemWrite,
  output logic [1:0]  MemSrc,
  output logic [2:0]  MemDst,
  output logic        PCWrite,
  output logic [2:0]  PCSrc,
  output logic        SPWrite,
  output logic [2:0]  SPSrc,
  output logic        InstWrite,
  output logic        mary_write,
  output logic [1:0]  mary_src,
  output logic        shelley_write,
  output logic [1:0]  shelley_src,
  output logic        comp_write,
  output logic        ra_write,
  output logic        ra_src,
  output logic        SrcA,
  output logic [1:0]  SrcB,
  output logic [3:0]  AluOp,
  output logic        halted,
  output logic        trap
);
  state_t state_q, state_d;
  logic active_q;
  ctrl_t dec, o;
  logic [3:0] op;
  logic unused_bits;
  assign op = instruction[15:12];
  assign unused_bits = ^{instruction[11:0], overflow};
  // active_q holds outputs at zero through reset and the first edge after release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      active_q <= 1'b1;
    end
  end
  // next-state sequencing; undefined opcodes fall back to FETCH as a NOP
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE:
        case (op)
          OP_AADD, OP_ASUB, OP_CMP: state_d = EXEC;
          OP_LDM, OP_LDS: state_d = MEMRD;
          OP_STM: state_d = STORE;
          OP_JMP, OP_BEQ: state_d = BRANCH;
          OP_CALL: state_d = CALL;
          OP_RET: state_d = RET;
          OP_HALT: state_d = HALT;
          default: state_d = FETCH;
        endcase
`ifdef OVERFLOW_TRAP_EN
      EXEC: state_d = (op == OP_CMP) ? FETCH : overflow ? TRAP : WB;
`else
      EXEC: state_d = (op == OP_CMP) ? FETCH : WB;
`endif
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
    if (!active_q) state_d = FETCH;
  end
  control_output_decode u_dec (
    .state_i (state_q),
    .opcode_i(op),
    .comp_i  (comp),
    .ctrl_o  (dec)
  );
  assign o = active_q ? dec : '0;
  assign MemWrite = o.mem_write;
  assign MemSrc = o.mem_src;
  assign MemDst = o.mem_dst;
  assign PCWrite = o.pc_write;
  assign PCSrc = o.pc_src;
  assign SPWrite = o.sp_write;
  assign SPSrc = o.sp_src;
  assign InstWrite = o.inst_write;
  assign mary_write = o.mary_write;
  assign mary_src = o.mary_src;
  assign shelley_write = o.shelley_write;
  assign shelley_src = o.shelley_src;
  assign comp_write = o.comp_write;
  assign ra_write = o.ra_write;
  assign ra_src = o.ra_src;
  assign SrcA = o.src_a;
  assign SrcB = o.src_b;
  assign AluOp = o.alu_op;
  assign halted = o.halted;
  assign trap = o.trap;
endmodule
